// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader that sits in front of the pipelined CPU.
// Takes a byte stream over a valid/ready handshake and writes 16-bit
// instructions into instruction memory, starting at address 0. It holds the
// CPU disabled while loading. After a good load it enables the CPU and pulses
// cpu_start.
// Frame: N (0 means 256 words), then N words sent high byte first, then an
// optional checksum byte.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, a
// trailing XOR checksum over the payload bytes is required and checked. When
// it is undefined, there is no checksum byte and err is tied to 0.
`timescale 1ns/1ps

module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] i_addr,
  output logic              i_we,
  output logic [DATA_W-1:0] i_dataout,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Word count must hold 256 (header byte 0), so it is one bit wider than a byte.
  localparam int CNT_W = 9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_START = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;
`endif

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hi_reg;
  logic [7:0]        lo_reg;
  logic              accept;
  logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // A byte is consumed only in the states that are waiting for stream data.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state == S_HDR) || (state == S_HI) ||
                      (state == S_LO)  || (state == S_CSUM);
`else
  assign byte_ready = (state == S_HDR) || (state == S_HI) || (state == S_LO);
`endif

  assign accept    = byte_valid && byte_ready;
  assign last_word = (cnt == CNT_W'(1));

  // Memory write port and CPU start pulse are decoded straight from the state.
  assign i_we      = (state == S_WR);
  assign i_addr    = addr;
  assign i_dataout = {hi_reg, lo_reg};
  assign cpu_start = (state == S_START);

`ifndef IMEM_LOADER_CHECKSUM_EN
  assign err = 1'b0;
`endif

  // Load sequencer: header, word assembly, write, optional check, CPU start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      addr       <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_enable <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
      err        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // A new request halts the CPU and clears the previous load's status.
          if (load_req) begin
            state      <= S_HDR;
            busy       <= 1'b1;
            done       <= 1'b0;
            cpu_enable <= 1'b0;
            addr       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            err        <= 1'b0;
            csum       <= '0;
`endif
          end
        end

        S_HDR: begin
          if (accept) begin
            cnt   <= (byte_data == 8'd0) ? CNT_W'(256) : CNT_W'(byte_data);
            state <= S_HI;
          end
        end

        S_HI: begin
          if (accept) begin
            hi_reg <= byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum   <= csum ^ byte_data;
`endif
            state  <= S_LO;
          end
        end

        S_LO: begin
          if (accept) begin
            lo_reg <= byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum   <= csum ^ byte_data;
`endif
            state  <= S_WR;
          end
        end

        S_WR: begin
          // The address wraps naturally, so a 256-word load leaves addr at 0.
          addr <= addr + 1'b1;
          cnt  <= cnt - CNT_W'(1);
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= S_CSUM;
`else
            state <= S_START;
`endif
          end else begin
            state <= S_HI;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            state <= (byte_data == csum) ? S_START : S_ERR;
          end
        end

        S_ERR: begin
          // The CPU is left disabled: it never saw the bad image.
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
`endif

        S_START: begin
          cpu_enable <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader. It covers reset, a basic two-word load,
// a checksum error (checksum builds only), a 256-word load with address wrap,
// a throttled stream with stray load_req pulses, and reset in the middle of a
// load.
`timescale 1ns/1ps

module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        load_req;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [7:0]  i_addr;
  logic        i_we;
  logic [15:0] i_dataout;
  logic        cpu_enable;
  logic        cpu_start;
  logic        busy;
  logic        done;
  logic        err;

  int vectors;
  int miscompares;

  // Write/start recorder filled from the DUT outputs on the falling edge.
  logic [15:0] mem [256];
  logic [7:0]  wr_log [1024];
  int          wr_cnt;
  int          start_cnt;

  imem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .i_addr     (i_addr),
    .i_we       (i_we),
    .i_dataout  (i_dataout),
    .cpu_enable (cpu_enable),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b1 && i_we === 1'b1) begin
      mem[i_addr] = i_dataout;
      if (wr_cnt < 1024) wr_log[wr_cnt] = i_addr;
      wr_cnt++;
    end
    if (rst === 1'b1 && cpu_start === 1'b1) start_cnt++;
  end

  // Present one byte and hold it until it is taken. Before that, optionally
  // leave byte_valid low for a few idle cycles and pulse load_req at random.
  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit noise);
    int gap;
    int n;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      load_req   = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      @(posedge clk); #1;
    end
    load_req   = 1'b0;
    byte_data  = b;
    byte_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (byte_ready === 1'b1) break;
      n++;
      if (n > 64) begin
        vectors++;
        miscompares++;
        $display("FAIL byte_accept_timeout: byte %h not taken within 64 cycles", b);
        byte_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    @(posedge clk); #1;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Checksum byte, or the single cycle from the final write to START.
  task automatic send_tail(input logic [7:0] chk);
    if (CSUM_ON) send_byte(chk, 0, 1'b0);
    else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (err !== 1'b0)        begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (cpu_enable !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_enable: got %b want 0", cpu_enable); end
    vectors++; if (cpu_start !== 1'b0)  begin miscompares++; $display("FAIL reset_cpu_start: got %b want 0", cpu_start); end
    vectors++; if (i_we !== 1'b0)       begin miscompares++; $display("FAIL reset_i_we: got %b want 0", i_we); end
    vectors++; if (i_addr !== 8'h00)    begin miscompares++; $display("FAIL reset_i_addr: got %h want 00", i_addr); end
    vectors++; if (i_dataout !== 16'h0) begin miscompares++; $display("FAIL reset_i_dataout: got %h want 0000", i_dataout); end
    vectors++; if (byte_ready !== 1'b0) begin miscompares++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (byte_ready !== 1'b0) begin miscompares++; $display("FAIL idle_byte_ready: got %b want 0", byte_ready); end
  endtask

  task automatic test_basic_load();
    int base_w;
    int base_s;
    base_w = wr_cnt;
    base_s = start_cnt;
    pulse_load_req();
    vectors++; if (busy !== 1'b1)       begin miscompares++; $display("FAIL basic_busy: got %b want 1", busy); end
    vectors++; if (byte_ready !== 1'b1) begin miscompares++; $display("FAIL basic_hdr_ready: got %b want 1", byte_ready); end
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    send_byte(8'hCD, 0, 1'b0);
    vectors++; if (i_we !== 1'b1)           begin miscompares++; $display("FAIL basic_we_latency: got %b want 1", i_we); end
    vectors++; if (i_addr !== 8'h01)        begin miscompares++; $display("FAIL basic_wr_addr: got %h want 01", i_addr); end
    vectors++; if (i_dataout !== 16'hABCD)  begin miscompares++; $display("FAIL basic_wr_data: got %h want abcd", i_dataout); end
    send_tail(8'h40);
    vectors++; if (cpu_start !== 1'b1)      begin miscompares++; $display("FAIL basic_cpu_start: got %b want 1", cpu_start); end
    vectors++; if (i_we !== 1'b0)           begin miscompares++; $display("FAIL basic_we_single: got %b want 0", i_we); end
    @(posedge clk); #1;
    vectors++; if (cpu_start !== 1'b0)      begin miscompares++; $display("FAIL basic_start_pulse: got %b want 0", cpu_start); end
    vectors++; if (done !== 1'b1)           begin miscompares++; $display("FAIL basic_done: got %b want 1", done); end
    vectors++; if (cpu_enable !== 1'b1)     begin miscompares++; $display("FAIL basic_cpu_enable: got %b want 1", cpu_enable); end
    vectors++; if (busy !== 1'b0)           begin miscompares++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    vectors++; if (err !== 1'b0)            begin miscompares++; $display("FAIL basic_err: got %b want 0", err); end
    vectors++; if (wr_cnt - base_w !== 2)   begin miscompares++; $display("FAIL basic_write_count: got %0d want 2", wr_cnt - base_w); end
    vectors++; if (wr_log[base_w] !== 8'h00) begin miscompares++; $display("FAIL basic_first_addr: got %h want 00", wr_log[base_w]); end
    vectors++; if (mem[0] !== 16'h1234)     begin miscompares++; $display("FAIL basic_mem0: got %h want 1234", mem[0]); end
    vectors++; if (mem[1] !== 16'hABCD)     begin miscompares++; $display("FAIL basic_mem1: got %h want abcd", mem[1]); end
    vectors++; if (start_cnt - base_s !== 1) begin miscompares++; $display("FAIL basic_start_count: got %0d want 1", start_cnt - base_s); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_error();
    int base_s;
    base_s = start_cnt;
    pulse_load_req();
    vectors++; if (cpu_enable !== 1'b0) begin miscompares++; $display("FAIL csum_halt: got %b want 0", cpu_enable); end
    vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL csum_done_clr: got %b want 0", done); end
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    send_byte(8'hCD, 0, 1'b0);
    send_byte(8'h41, 0, 1'b0);
    vectors++; if (cpu_start !== 1'b0)  begin miscompares++; $display("FAIL csum_no_start: got %b want 0", cpu_start); end
    @(posedge clk); #1;
    vectors++; if (err !== 1'b1)        begin miscompares++; $display("FAIL csum_err: got %b want 1", err); end
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL csum_busy: got %b want 0", busy); end
    vectors++; if (cpu_enable !== 1'b0) begin miscompares++; $display("FAIL csum_cpu_enable: got %b want 0", cpu_enable); end
    vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL csum_done: got %b want 0", done); end
    vectors++; if (start_cnt !== base_s) begin miscompares++; $display("FAIL csum_start_count: got %0d want %0d", start_cnt, base_s); end
  endtask
`endif

  // Header 0 means 256 words: word k = {k, k^5A}; the payload XOR is 00.
  task automatic test_full_256();
    int base_w;
    int base_s;
    logic [7:0] k8;
    base_w = wr_cnt;
    base_s = start_cnt;
    pulse_load_req();
    send_byte(8'h00, 0, 1'b0);
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      send_byte(k8, 0, 1'b0);
      send_byte(k8 ^ 8'h5A, 0, 1'b0);
    end
    send_tail(8'h00);
    vectors++; if (cpu_start !== 1'b1)    begin miscompares++; $display("FAIL full_cpu_start: got %b want 1", cpu_start); end
    vectors++; if (i_addr !== 8'h00)      begin miscompares++; $display("FAIL full_addr_wrap: got %h want 00", i_addr); end
    @(posedge clk); #1;
    vectors++; if (done !== 1'b1)         begin miscompares++; $display("FAIL full_done: got %b want 1", done); end
    vectors++; if (wr_cnt - base_w !== 256) begin miscompares++; $display("FAIL full_write_count: got %0d want 256", wr_cnt - base_w); end
    vectors++; if (start_cnt - base_s !== 1) begin miscompares++; $display("FAIL full_start_count: got %0d want 1", start_cnt - base_s); end
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      vectors++;
      if (wr_log[base_w + k] !== k8) begin
        miscompares++;
        $display("FAIL full_addr_seq[%0d]: got %h want %h", k, wr_log[base_w + k], k8);
      end
      vectors++;
      if (mem[k] !== {k8, k8 ^ 8'h5A}) begin
        miscompares++;
        $display("FAIL full_mem[%0d]: got %h want %h", k, mem[k], {k8, k8 ^ 8'h5A});
      end
    end
  endtask

  // Same image as the basic load, sent with gaps and stray load_req pulses.
  task automatic test_back_to_back();
    int base_w;
    int base_s;
    base_w = wr_cnt;
    base_s = start_cnt;
    mem[0] = 16'h0000;
    mem[1] = 16'h0000;
    pulse_load_req();
    send_byte(8'h02, 3, 1'b1);
    send_byte(8'h12, 3, 1'b1);
    send_byte(8'h34, 3, 1'b1);
    send_byte(8'hAB, 3, 1'b1);
    send_byte(8'hCD, 3, 1'b1);
    if (CSUM_ON) send_byte(8'h40, 3, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (done !== 1'b1)           begin miscompares++; $display("FAIL b2b_done: got %b want 1", done); end
    vectors++; if (busy !== 1'b0)           begin miscompares++; $display("FAIL b2b_busy: got %b want 0", busy); end
    vectors++; if (cpu_enable !== 1'b1)     begin miscompares++; $display("FAIL b2b_cpu_enable: got %b want 1", cpu_enable); end
    vectors++; if (wr_cnt - base_w !== 2)   begin miscompares++; $display("FAIL b2b_write_count: got %0d want 2", wr_cnt - base_w); end
    vectors++; if (wr_log[base_w] !== 8'h00)     begin miscompares++; $display("FAIL b2b_addr0: got %h want 00", wr_log[base_w]); end
    vectors++; if (wr_log[base_w + 1] !== 8'h01) begin miscompares++; $display("FAIL b2b_addr1: got %h want 01", wr_log[base_w + 1]); end
    vectors++; if (mem[0] !== 16'h1234)     begin miscompares++; $display("FAIL b2b_mem0: got %h want 1234", mem[0]); end
    vectors++; if (mem[1] !== 16'hABCD)     begin miscompares++; $display("FAIL b2b_mem1: got %h want abcd", mem[1]); end
    vectors++; if (start_cnt - base_s !== 1) begin miscompares++; $display("FAIL b2b_start_count: got %0d want 1", start_cnt - base_s); end
  endtask

  task automatic test_reset_midload();
    int base_w;
    int base_s;
    base_w = wr_cnt;
    pulse_load_req();
    send_byte(8'h05, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0); send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0); send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0); send_byte(8'h33, 0, 1'b0);
    @(posedge clk); #1;
    vectors++; if (wr_cnt - base_w !== 3) begin miscompares++; $display("FAIL mid_writes_before: got %0d want 3", wr_cnt - base_w); end
    vectors++; if (busy !== 1'b1)         begin miscompares++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0)         begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
    vectors++; if (i_we !== 1'b0)         begin miscompares++; $display("FAIL mid_i_we: got %b want 0", i_we); end
    vectors++; if (cpu_enable !== 1'b0)   begin miscompares++; $display("FAIL mid_cpu_enable: got %b want 0", cpu_enable); end
    vectors++; if (byte_ready !== 1'b0)   begin miscompares++; $display("FAIL mid_byte_ready: got %b want 0", byte_ready); end
    vectors++; if (i_addr !== 8'h00)      begin miscompares++; $display("FAIL mid_i_addr: got %h want 00", i_addr); end
    @(negedge clk);
    rst = 1'b1;
    base_w = wr_cnt;
    base_s = start_cnt;
    pulse_load_req();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h55, 0, 1'b0); send_byte(8'h55, 0, 1'b0);
    send_byte(8'h66, 0, 1'b0); send_byte(8'h66, 0, 1'b0);
    send_tail(8'h00);
    @(posedge clk); #1;
    vectors++; if (wr_log[base_w] !== 8'h00) begin miscompares++; $display("FAIL mid_restart_addr: got %h want 00", wr_log[base_w]); end
    vectors++; if (mem[0] !== 16'h5555)   begin miscompares++; $display("FAIL mid_mem0: got %h want 5555", mem[0]); end
    vectors++; if (mem[1] !== 16'h6666)   begin miscompares++; $display("FAIL mid_mem1: got %h want 6666", mem[1]); end
    vectors++; if (done !== 1'b1)         begin miscompares++; $display("FAIL mid_done: got %b want 1", done); end
    vectors++; if (start_cnt - base_s !== 1) begin miscompares++; $display("FAIL mid_start_count: got %0d want 1", start_cnt - base_s); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    wr_cnt      = 0;
    start_cnt   = 0;
    rst         = 1'b1;
    load_req    = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    test_reset();
    test_basic_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_error();
`endif
    test_full_256();
    test_back_to_back();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
